// File: rtl/rom_string_reader_if.sv
// rtl/rom_string_reader_if.sv - command and byte-stream handshake bundle for rom_string_reader
interface rom_string_reader_if #(
   parameter int ADDR_W = 6,
   parameter int DATA_W = 8
);
   logic              cmd_valid;
   logic              cmd_ready;
   logic [ADDR_W-1:0] cmd_addr;
   logic [ADDR_W-1:0] cmd_len;
   logic [DATA_W-1:0] out_data;
   logic              out_valid;
   logic              out_ready;
   logic              out_last;

   modport master (
      output cmd_valid, cmd_addr, cmd_len, out_ready,
      input  cmd_ready, out_data, out_valid, out_last
   );

   modport slave (
      input  cmd_valid, cmd_addr, cmd_len, out_ready,
      output cmd_ready, out_data, out_valid, out_last
   );
endinterface

// File: rtl/rom_string_reader.sv
// rtl/rom_string_reader.sv - walks the 64x8 character ROM for one string command and streams its bytes
// Optional trailing space byte enabled by defining SPACE_INSERT_EN.
module rom_string_reader #(
   parameter int ADDR_W     = 6,
   parameter int DATA_W     = 8,
   parameter int SPACE_ADDR = 47
) (
   input  logic                 clk,
   input  logic                 rst_n,
   rom_string_reader_if.slave   bus,
   output logic [ADDR_W-1:0]    rom_addr,
   input  logic [DATA_W-1:0]    rom_d,
   output logic                 busy,
   output logic                 done
);

`ifdef SPACE_INSERT_EN
   localparam bit SPACE_EN = 1'b1;
`else
   localparam bit SPACE_EN = 1'b0;
`endif

   localparam logic [2:0] IDLE = 3'd0;
   localparam logic [2:0] RD0  = 3'd1;
   localparam logic [2:0] RD1  = 3'd2;
   localparam logic [2:0] SEND = 3'd3;
   localparam logic [2:0] FIN  = 3'd4;

   localparam logic [ADDR_W-1:0] SPACE_ADDR_C = ADDR_W'(SPACE_ADDR);
   localparam logic [ADDR_W-1:0] ONE          = ADDR_W'(1);
   localparam logic [ADDR_W-1:0] ZERO         = '0;

   logic [2:0]        state_q, state_d;
   logic [ADDR_W-1:0] ptr_q, ptr_d;
   logic [ADDR_W-1:0] rem_q, rem_d;
   logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
   logic [DATA_W-1:0] out_data_q, out_data_d;
   logic              out_valid_q, out_valid_d;
   logic              out_last_q, out_last_d;
   logic              space_q, space_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;

   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      rem_d       = rem_q;
      rom_addr_d  = rom_addr_q;
      out_data_d  = out_data_q;
      out_valid_d = out_valid_q;
      out_last_d  = out_last_q;
      space_d     = space_q;
      case (state_q)
         IDLE: begin
            if (bus.cmd_valid) begin
               ptr_d      = bus.cmd_addr;
               rem_d      = bus.cmd_len;
               rom_addr_d = bus.cmd_addr;
               space_d    = 1'b0;
               if (bus.cmd_len != ZERO) begin
                  state_d = RD0;
               end else if (SPACE_EN) begin
                  space_d    = 1'b1;
                  rom_addr_d = SPACE_ADDR_C;
                  state_d    = RD0;
               end else begin
                  state_d = FIN;
               end
            end
         end
         RD0: state_d = RD1;
         RD1: begin
            out_data_d  = rom_d;
            out_valid_d = 1'b1;
            // With the trailing space enabled, only the space byte carries last.
            out_last_d  = space_q || (!SPACE_EN && rem_q == ONE);
            state_d     = SEND;
         end
         SEND: begin
            if (out_valid_q && bus.out_ready) begin
               out_valid_d = 1'b0;
               out_last_d  = 1'b0;
               if (space_q) begin
                  state_d = FIN;
               end else begin
                  rem_d = rem_q - ONE;
                  if (rem_q > ONE) begin
                     ptr_d      = ptr_q + ONE;
                     rom_addr_d = ptr_q + ONE;
                     state_d    = RD0;
                  end else if (SPACE_EN) begin
                     space_d    = 1'b1;
                     rom_addr_d = SPACE_ADDR_C;
                     state_d    = RD0;
                  end else begin
                     state_d = FIN;
                  end
               end
            end
         end
         FIN:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
      done_d = (state_d == FIN);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         ptr_q       <= '0;
         rem_q       <= '0;
         rom_addr_q  <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         space_q     <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         rem_q       <= rem_d;
         rom_addr_q  <= rom_addr_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         out_last_q  <= out_last_d;
         space_q     <= space_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign bus.cmd_ready = (state_q == IDLE);
   assign bus.out_data  = out_data_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_last  = out_last_q;
   assign rom_addr      = rom_addr_q;
   assign busy          = busy_q;
   assign done          = done_q;

endmodule

// File: doc/rom_string_reader.md
Name: rom_string_reader

Overview:
- Sequencer for the 64x8 synchronous character ROM: 6-bit address, data registered on posedge clk, one-cycle read latency.
- Accepts a string command (start address, length) from one requester, walks the ROM addresses and streams the bytes out on a valid/ready byte interface, e.g. toward a UART TX or display writer.
- Only block that drives the ROM address; requesters never touch the ROM directly.

Parameters:
- ADDR_W, 6, ROM address width
- DATA_W, 8, ROM data / output byte width
- SPACE_ADDR, 47, ROM address of the ASCII space character (used only with the optional feature)

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  asynchronous, active-low reset
- cmd_valid  input  1  command request
- cmd_ready  output  1  high only in IDLE
- cmd_addr  input  ADDR_W  first ROM address of string
- cmd_len  input  ADDR_W  byte count, 0..63
- rom_addr  output  ADDR_W  to ROM addr, registered
- rom_d  input  DATA_W  from ROM d
- out_data  output  DATA_W  streamed byte
- out_valid  output  1  out_data valid
- out_ready  input  1  consumer accepts byte
- out_last  output  1  qualifies final byte of command
- busy  output  1  high in any state except IDLE
- done  output  1  one-cycle pulse when command completes

Behaviour:
- Reset (async assert, sync release): state=IDLE, rom_addr=0, out_data=0, out_valid=0, out_last=0, done=0, busy=0, internal ptr=0, remaining count=0.
- States: IDLE, RD0, RD1, SEND, FIN.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid: latch ptr=cmd_addr and rem=cmd_len, and set rom_addr=cmd_addr.
  - If cmd_len=0, go to FIN; otherwise go to RD0.
- RD0: rom_addr stable; the ROM samples it at the end of this cycle. Go to RD1.
- RD1:
  - rom_d is valid.
  - At the end of the cycle: out_data<=rom_d, out_valid<=1, out_last<=(rem==1).
  - Go to SEND.
- SEND:
  - out_data, out_valid and out_last are held stable until out_ready=1.
  - A transfer is the cycle where out_valid and out_ready are both 1.
  - On transfer: out_valid<=0, out_last<=0, rem<=rem-1.
  - If rem>1: ptr<=ptr+1, rom_addr<=ptr+1, go to RD0.
  - Otherwise go to FIN.
- FIN: done=1 for exactly this cycle; go to IDLE.
- Latency:
  - First out_valid is asserted 3 rising edges after the cmd accept edge (accept, end RD0, end RD1).
  - Minimum 3 cycles per byte with out_ready held high.
- Address arithmetic is modulo 2^ADDR_W: ptr 63 + 1 -> 0, with no error flag.
- Commands presented while busy are ignored (cmd_ready=0); the requester must hold cmd_valid until accepted.
- out_ready is ignored while out_valid=0.
- Unmapped ROM locations are passed through as read; no filtering or checking of out_data.
- Reset asserted mid-operation: all outputs immediately return to reset values and the current command is dropped with no done pulse.
- busy and done are registered state decodes, glitch-free.

Optional Feature:
- Macro SPACE_INSERT_EN.
- When defined:
  - After the last string byte transfers (rem reaches 0), the block performs one extra read of SPACE_ADDR through RD0/RD1/SEND.
  - The emitted byte is 0x20, with out_last on it instead of on the final string byte. Then FIN.
  - For cmd_len=0, only the space byte is emitted.
- When undefined: no extra read; behaviour exactly as above.

Test Plan:
- Student code: cmd_addr=0, cmd_len=9, out_ready=1 -> bytes 0x32,0x31,0x30,0x31,0x36,0x38,0x34,0x35,0x37.
  - out_last only on 0x37; first out_valid 3 edges after accept; bytes 3 cycles apart; done pulse one cycle after final transfer.
- Backpressure: cmd_addr=9, cmd_len=6, out_ready low 5 cycles on byte 2 -> out_data held at 0x45 with out_valid=1 throughout; full stream "HECTOR" (0x48,0x45,0x43,0x54,0x4F,0x52) with no loss or duplication.
- Zero length: cmd_len=0 -> no out_valid, busy high 1 cycle, done pulse, cmd_ready high again next cycle.
- Wrap: cmd_addr=62, cmd_len=3 -> rom_addr sequence 62,63,0; third byte 0x32 with out_last.
- Reset mid-stream: assert rst_n=0 during SEND of byte 4 of the surname (cmd_addr=29, cmd_len=8) -> out_valid/busy drop asynchronously, no done.
  - After release, new cmd (47,1) -> single byte 0x20.
- SPACE_INSERT_EN build: cmd_addr=15, cmd_len=7 -> "EDUARDO" then 0x20, out_last on 0x20 only, then done.
  - Without the macro the same command ends on 0x4F with out_last.
